// File: rtl/fpga_gpio_pad_exerciser.sv
// GPIO pad exerciser: drives a stimulus vector onto the fabric's GPIN pads,
// waits a programmable settle time, then returns the synchronised GPOUT level
// and the number of GPOUT rising edges seen during the window to the host.
module fpga_gpio_pad_exerciser #(
    parameter int NUM_IN   = 8,
    parameter int SETTLE_W = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NUM_IN-1:0]   req_vec,
    output logic [NUM_IN-1:0]   gpin_pad_o,
    output logic                gpin_oe,
    input  logic                gpout_pad_i,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_bit,
    output logic [CNT_W-1:0]    rsp_edges,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]    EDGE_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    EDGE_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SETTLE_W-1:0] SETTLE_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};
    localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};

    state_t                state_q;
    logic                  sync1_q;
    logic                  sync_q;
    logic                  sync_d_q;
    logic [SETTLE_W-1:0]   settle_cfg_q;
    logic [SETTLE_W-1:0]   settle_cnt_q;
    logic [CNT_W-1:0]      edges_q;
    logic [NUM_IN-1:0]     gpin_pad_q;
    logic                  gpin_oe_q;
    logic                  req_ready_q;
    logic                  busy_q;
    logic                  rsp_valid_q;
    logic                  rsp_bit_q;
    logic                  rise_s;
    logic                  in_window_s;
    logic                  accept_s;

    // The GPOUT pad is asynchronous: two flops resolve metastability, a third
    // keeps the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            sync_d_q <= 1'b0;
        end else begin
            sync1_q  <= gpout_pad_i;
            sync_q   <= sync1_q;
            sync_d_q <= sync_q;
        end
    end

    assign rise_s      = sync_q & ~sync_d_q;
    assign in_window_s = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
    assign accept_s    = (state_q == IDLE) && req_valid;

    // Rising-edge counter: cleared when a request is accepted, counts only
    // inside the observation window and sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges_q <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            edges_q <= {CNT_W{1'b0}};
        end else if (in_window_s && rise_s && (edges_q != EDGE_MAX)) begin
            edges_q <= edges_q + EDGE_ONE;
        end else begin
            edges_q <= edges_q;
        end
    end

    // Sequencer: accept, drive pads, settle, sample, then hold the response
    // until the host takes it. All host-visible outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cfg_q <= {SETTLE_W{1'b0}};
            settle_cnt_q <= {SETTLE_W{1'b0}};
            gpin_pad_q   <= {NUM_IN{1'b0}};
            gpin_oe_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_bit_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        gpin_pad_q   <= req_vec;
                        gpin_oe_q    <= 1'b1;
                        settle_cfg_q <= cfg_settle;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= DRIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRIVE: begin
                    if (settle_cfg_q != SETTLE_ZERO) begin
                        settle_cnt_q <= settle_cfg_q;
                        state_q      <= SETTLE;
                    end else begin
                        state_q <= SAMPLE;
                    end
                end
                SETTLE: begin
                    // Counter reads S on the first settle cycle, so leaving
                    // when it reads 1 gives exactly S cycles; it never wraps.
                    settle_cnt_q <= settle_cnt_q - SETTLE_ONE;
                    if (settle_cnt_q == SETTLE_ONE) begin
                        state_q <= SAMPLE;
                    end else begin
                        state_q <= SETTLE;
                    end
                end
                SAMPLE: begin
                    rsp_bit_q   <= sync_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign gpin_pad_o = gpin_pad_q;
    assign gpin_oe    = gpin_oe_q;
    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_bit    = rsp_bit_q;
    assign rsp_edges  = edges_q;

endmodule

// File: tb/tb_fpga_gpio_pad_exerciser.sv
// Self-checking bench for fpga_gpio_pad_exerciser. A pad model drives GPOUT
// (AND of the expected GPIN vector, a slow toggle, or random noise) and logs
// its level per cycle; expectations are derived from that log.
module tb_fpga_gpio_pad_exerciser;

    logic       clk;
    logic       rst_n;
    logic [7:0] cfg_settle;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_vec;
    logic [7:0] gpin_pad_o;
    logic       gpin_oe;
    logic       gpout_pad_i;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_bit;
    logic [3:0] rsp_edges;
    logic       busy;

    int         n_pass;
    int         n_total;
    int         cyc;
    int         mode;          // 0: AND of pads, 1: toggle every 2 cycles, 2: random
    logic [7:0] model_pad;
    bit         hist [int];    // GPOUT level during each cycle

    fpga_gpio_pad_exerciser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_settle  (cfg_settle),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_vec     (req_vec),
        .gpin_pad_o  (gpin_pad_o),
        .gpin_oe     (gpin_oe),
        .gpout_pad_i (gpout_pad_i),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_bit     (rsp_bit),
        .rsp_edges   (rsp_edges),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: during cycle c (between edges) cyc == c.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fabric pad model, updated shortly after each edge.
    initial begin
        bit g;
        gpout_pad_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) g = 1'b0;
            else if (mode == 0) g = &model_pad;
            else if (mode == 1) g = cyc[1];
            else g = 1'($urandom & 32'd1);
            gpout_pad_i = g;
            hist[cyc] = g;
        end
    end

    function automatic bit h(input int c);
        return hist.exists(c) ? hist[c] : 1'b0;
    endfunction

    // Pad changes appear on the synchronised signal two cycles later; a rise
    // seen in cycle k is a 0->1 pad change between cycles k-3 and k-2.
    function automatic int exp_edge_count(input int t, input int s);
        int n;
        n = 0;
        for (int k = t + 1; k <= t + 2 + s; k++)
            if (h(k - 2) && !h(k - 3) && n < 15) n++;
        return n;
    endfunction

    // One full transaction; entered between edges while the DUT is idle,
    // returns between edges in the first idle cycle after the handshake.
    task automatic do_txn(input logic [7:0] vec, input logic [7:0] s, input int m,
                          input int hold, input bit poke);
        int t, exp_e, got;
        bit done, exp_b;
        logic       b0;
        logic [3:0] e0;
        mode = m;
        req_vec = vec; cfg_settle = s; req_valid = 1'b1; t = cyc;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL txn_ready_idle: got %b want 1", req_ready); else n_pass++;
        @(posedge clk); #1;
        req_valid = 1'b0; model_pad = vec;
        @(negedge clk);
        n_total++;
        if (gpin_pad_o !== vec || gpin_oe !== 1'b1)
            $display("FAIL txn_drive: pad %h oe %b want %h 1", gpin_pad_o, gpin_oe, vec);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1 || req_ready !== 1'b0)
            $display("FAIL txn_busy: busy %b ready %b want 1 0", busy, req_ready);
        else n_pass++;
        done = 1'b0;
        for (int i = 0; i < s + 8 && !done; i++) begin
            if (rsp_valid === 1'b1) done = 1'b1;
            else @(negedge clk);
        end
        n_total++;
        if (!done) begin
            $display("FAIL txn_timeout: no rsp_valid by cycle %0d want %0d", cyc, t + 3 + s);
            return;
        end else n_pass++;
        got = cyc;
        n_total++;
        if (got != t + 3 + s) $display("FAIL txn_latency: got %0d want %0d", got - t, 3 + s); else n_pass++;
        exp_e = exp_edge_count(t, s);
        exp_b = h(t + s);
        n_total++;
        if (rsp_bit !== exp_b) $display("FAIL txn_bit: got %b want %b", rsp_bit, exp_b); else n_pass++;
        n_total++;
        if (rsp_edges !== 4'(exp_e)) $display("FAIL txn_edges: got %0d want %0d", rsp_edges, exp_e); else n_pass++;
        b0 = exp_b; e0 = 4'(exp_e);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin req_valid = 1'b1; req_vec = 8'($urandom); cfg_settle = 8'd0; end
            @(negedge clk);
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_bit !== b0 || rsp_edges !== e0 || req_ready !== 1'b0 || gpin_pad_o !== vec)
                $display("FAIL hold_stable: v %b b %b e %0d rdy %b pad %h want 1 %b %0d 0 %h",
                         rsp_valid, rsp_bit, rsp_edges, req_ready, gpin_pad_o, b0, e0, vec);
            else n_pass++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || gpin_pad_o !== vec || gpin_oe !== 1'b1)
            $display("FAIL txn_release: v %b rdy %b busy %b pad %h oe %b want 0 1 0 %h 1",
                     rsp_valid, req_ready, busy, gpin_pad_o, gpin_oe, vec);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || gpin_oe !== 1'b0 || gpin_pad_o !== 8'h00 ||
            rsp_valid !== 1'b0 || rsp_bit !== 1'b0 || rsp_edges !== 4'd0)
            $display("FAIL reset_values: rdy %b busy %b oe %b pad %h v %b b %b e %0d",
                     req_ready, busy, gpin_oe, gpin_pad_o, rsp_valid, rsp_bit, rsp_edges);
        else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        do_txn(8'hFF, 8'd4, 0, 0, 1'b0);
        do_txn(8'hFE, 8'd4, 0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        // Pads are non-zero here; reset must clear them without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        model_pad = 8'h00;
        n_total++;
        if (gpin_pad_o !== 8'h00 || gpin_oe !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL async_reset: pad %h oe %b rdy %b busy %b v %b", gpin_pad_o, gpin_oe, req_ready, busy, rsp_valid);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_txn(8'($urandom), 8'($urandom_range(6, 1)), 0, 10, 1'b1);
    endtask

    task automatic test_saturation();
        do_txn(8'($urandom), 8'd60, 1, 0, 1'b0);
        n_total++;
        if (rsp_edges !== 4'd15) $display("FAIL sat_edges: got %0d want 15", rsp_edges); else n_pass++;
    endtask

    task automatic test_settle_bounds();
        do_txn(8'($urandom), 8'd0, 2, 0, 1'b0);
        do_txn(8'($urandom), 8'd255, 2, 1, 1'b0);
    endtask

    task automatic test_reset_during_settle();
        bit seen;
        mode = 0;
        req_vec = 8'hFF; cfg_settle = 8'd20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; model_pad = 8'hFF;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_pad = 8'h00;
        n_total++;
        if (gpin_pad_o !== 8'h00 || gpin_oe !== 1'b0 || busy !== 1'b0)
            $display("FAIL settle_reset: pad %h oe %b busy %b want 00 0 0", gpin_pad_o, gpin_oe, busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL settle_reset_lost: rsp_valid 1 want 0"); else n_pass++;
        do_txn(8'hFF, 8'd3, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            do_txn(8'($urandom), 8'($urandom_range(15, 0)), int'($urandom_range(2, 0)),
                   int'($urandom_range(3, 0)), 1'($urandom & 32'd1));
    endtask

    initial begin
        n_pass = 0; n_total = 0; mode = 0; model_pad = 8'h00;
        req_valid = 1'b0; req_vec = 8'h00; cfg_settle = 8'd0; rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_async_reset();
        test_backpressure();
        test_saturation();
        test_settle_bounds();
        test_reset_during_settle();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
